// File: rtl/scpad_pkg.sv
// Shared types for the scratchpad read/write crossbar arbiters.
package scpad_pkg;

  // Wide enough for the largest supported requester count (8).
  localparam int unsigned SCPAD_ID_WIDTH = 3;
  localparam int unsigned XBAR_LATENCY   = 2;

  typedef logic [SCPAD_ID_WIDTH-1:0] arb_src_t;

  // One in-flight crossbar slot: did an issue happen, and who issued it.
  typedef struct packed {
    logic     valid;
    arb_src_t src;
  } shadow_ent_t;

endpackage

// File: rtl/scpad_rd_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first requester at or above i_ptr, wrapping.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_ptr,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [IDX_W-1:0]   o_idx,
  output logic               o_any
);

  logic [IDX_W:0]   w_sum;
  logic [IDX_W-1:0] w_cand;

  // Scan requesters starting at the pointer; first valid one wins.
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    w_sum   = '0;
    w_cand  = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      w_sum = {1'b0, i_ptr} + (IDX_W+1)'(k);
      if (w_sum >= (IDX_W+1)'(NUM_REQ)) begin
        w_sum = w_sum - (IDX_W+1)'(NUM_REQ);
      end
      w_cand = w_sum[IDX_W-1:0];
      if (!o_any && i_req[w_cand]) begin
        o_any           = 1'b1;
        o_grant[w_cand] = 1'b1;
        o_idx           = w_cand;
      end
    end
  end

endmodule

// File: rtl/scpad_rd_arbiter.sv
// Scratchpad read-port arbiter: round-robin issue into the crossbar, shadow
// tracking of in-flight sources, response steering and read-stall.
// Optional performance counters are built when SCPAD_ARB_PERF_EN is defined.
module scpad_rd_arbiter #(
  parameter int unsigned NUM_REQ      = 3,
  parameter int unsigned PAYLOAD_W    = 64,
  parameter int unsigned XBAR_LATENCY = scpad_pkg::XBAR_LATENCY,
  parameter int unsigned SRC_W        = $clog2(NUM_REQ)
) (
  input  logic                         clk,
  input  logic                         n_rst,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*PAYLOAD_W-1:0] req_payload,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic                         wr_busy,
  output logic                         xbar_valid,
  output logic [PAYLOAD_W-1:0]         xbar_payload,
  output logic [SRC_W-1:0]             xbar_src,
  output logic                         r_stall,
  input  logic                         res_valid,
  input  logic [SRC_W-1:0]             res_src,
  input  logic [NUM_REQ-1:0]           res_ready,
  output logic [NUM_REQ-1:0]           res_valid_out,
  output logic                         src_err
`ifdef SCPAD_ARB_PERF_EN
  ,
  output logic [NUM_REQ*32-1:0]        perf_grant_cnt,
  output logic [31:0]                  perf_stall_cnt
`endif
);

  import scpad_pkg::*;

  logic [NUM_REQ-1:0]   w_grant;
  logic [SRC_W-1:0]     w_idx;
  logic                 w_any;
  logic                 w_stall;
  logic                 w_can_issue;
  logic                 w_accept;
  logic [SRC_W-1:0]     w_ptr_nxt;
  logic [PAYLOAD_W-1:0] w_pay;
  logic                 w_mismatch;
  shadow_ent_t          w_tail;

  logic [SRC_W-1:0]     r_ptr;
  shadow_ent_t          r_shadow [XBAR_LATENCY];

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (SRC_W)
  ) u_rr (
    .i_req   (req_valid),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_any   (w_any)
  );

  assign w_stall     = res_valid & ~res_ready[res_src];
  assign w_can_issue = ~w_stall & ~wr_busy;
  assign w_accept    = w_can_issue & w_any;
  assign req_ready   = w_can_issue ? w_grant : '0;
  assign r_stall     = w_stall;
  assign w_ptr_nxt   = (w_idx == SRC_W'(NUM_REQ-1)) ? '0 : w_idx + 1'b1;

  // Select the granted requester's payload slice.
  always_comb begin
    w_pay = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (w_grant[i]) w_pay = req_payload[i*PAYLOAD_W +: PAYLOAD_W];
    end
  end

  // Steer the tail response to its requester, independent of stall.
  always_comb begin
    res_valid_out = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      res_valid_out[i] = res_valid & (res_src == SRC_W'(i));
    end
  end

  // The shadow pipeline is fed from the issue register, so a request issued
  // in cycle T is expected back at the tail in cycle T+XBAR_LATENCY.
  assign w_tail     = r_shadow[XBAR_LATENCY-1];
  assign w_mismatch = (w_tail.valid != res_valid) |
                      (w_tail.valid & (w_tail.src != arb_src_t'(res_src)));

  // Issue register, round-robin pointer, shadow pipeline and sticky error.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      xbar_valid   <= 1'b0;
      xbar_payload <= '0;
      xbar_src     <= '0;
      r_ptr        <= '0;
      src_err      <= 1'b0;
      for (int unsigned i = 0; i < XBAR_LATENCY; i++) r_shadow[i] <= '0;
    end else if (!w_stall) begin
      xbar_valid <= w_accept;
      if (w_accept) begin
        xbar_payload <= w_pay;
        xbar_src     <= w_idx;
        r_ptr        <= w_ptr_nxt;
      end
      r_shadow[0] <= {xbar_valid, arb_src_t'(xbar_src)};
      for (int unsigned i = 1; i < XBAR_LATENCY; i++) r_shadow[i] <= r_shadow[i-1];
      if (w_mismatch) src_err <= 1'b1;
    end
  end

`ifdef SCPAD_ARB_PERF_EN
  logic [31:0] r_grant_cnt [NUM_REQ];
  logic [31:0] r_stall_cnt;

  // Saturating per-requester grant counters and stall-cycle counter.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) r_grant_cnt[i] <= '0;
      r_stall_cnt <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (w_accept && w_grant[i] && (r_grant_cnt[i] != '1)) r_grant_cnt[i] <= r_grant_cnt[i] + 1'b1;
      end
      if (w_stall && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_perf
    assign perf_grant_cnt[g*32 +: 32] = r_grant_cnt[g];
  end
  assign perf_stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_scpad_rd_arbiter.sv
// Directed bench for scpad_rd_arbiter with a cycle-level behavioural model.
module tb_scpad_rd_arbiter;

  localparam int N = 3;
  localparam int L = 2;
  localparam int P = 64;

  typedef struct packed { logic v; logic [1:0] s; } ent_t;

  logic           clk = 1'b0;
  logic           n_rst = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [N*P-1:0] req_payload;
  logic [N-1:0]   req_ready;
  logic           wr_busy = 1'b0;
  logic           xbar_valid;
  logic [P-1:0]   xbar_payload;
  logic [1:0]     xbar_src;
  logic           r_stall;
  logic           res_valid = 1'b0;
  logic [1:0]     res_src = '0;
  logic [N-1:0]   res_ready = '1;
  logic [N-1:0]   res_valid_out;
  logic           src_err;
`ifdef SCPAD_ARB_PERF_EN
  logic [N*32-1:0] perf_grant_cnt;
  logic [31:0]     perf_stall_cnt;
`endif

  logic [P-1:0] pay [N];
  int n_checks = 0;
  int n_errs   = 0;
  bit auto_rsp = 1'b0;

  // Model state
  bit           m_known = 1'b0;
  int           m_ptr;
  logic         m_xv;
  logic [P-1:0] m_xp;
  logic [1:0]   m_xs;
  logic         m_err;
  ent_t         m_hist [$];

  always #5 clk = ~clk;

  scpad_rd_arbiter #(
    .NUM_REQ      (N),
    .PAYLOAD_W    (P),
    .XBAR_LATENCY (L),
    .SRC_W        (2)
  ) dut (
    .clk           (clk),
    .n_rst         (n_rst),
    .req_valid     (req_valid),
    .req_payload   (req_payload),
    .req_ready     (req_ready),
    .wr_busy       (wr_busy),
    .xbar_valid    (xbar_valid),
    .xbar_payload  (xbar_payload),
    .xbar_src      (xbar_src),
    .r_stall       (r_stall),
    .res_valid     (res_valid),
    .res_src       (res_src),
    .res_ready     (res_ready),
    .res_valid_out (res_valid_out),
    .src_err       (src_err)
`ifdef SCPAD_ARB_PERF_EN
    ,
    .perf_grant_cnt (perf_grant_cnt),
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int pick(input logic [N-1:0] rv, input int ptr);
    for (int k = 0; k < N; k++) begin
      if (rv[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  // Compare every output against the model, then advance the model one cycle.
  always @(negedge clk) begin
    int   g;
    logic stall;
    logic can;
    ent_t tail;
    stall = res_valid && !res_ready[res_src];
    can   = !stall && !wr_busy;
    g     = can ? pick(req_valid, m_ptr) : -1;
    if (m_known) begin
      chk("r_stall", r_stall, stall);
      chk("req_ready", req_ready, (g >= 0) ? (1 << g) : 0);
      chk("res_valid_out", res_valid_out, res_valid ? (1 << res_src) : 0);
      chk("xbar_valid", xbar_valid, m_xv);
      chk("xbar_src", xbar_src, m_xs);
      chk("xbar_payload", xbar_payload, m_xp);
      chk("src_err", src_err, m_err);
    end
    if (!n_rst) begin
      m_known = 1'b1;
      m_ptr = 0; m_xv = 1'b0; m_xp = '0; m_xs = '0; m_err = 1'b0;
      m_hist.delete();
      for (int i = 0; i < L; i++) m_hist.push_back('0);
    end else if (m_known && !stall) begin
      tail = m_hist.pop_front();
      if ((tail.v != res_valid) || (tail.v && (tail.s != res_src))) m_err = 1'b1;
      m_hist.push_back({m_xv, m_xs});
      m_xv = (g >= 0);
      if (g >= 0) begin
        m_xp  = pay[g];
        m_xs  = g[1:0];
        m_ptr = (g + 1) % N;
      end
    end
  end

  // Advance to just after the next rising edge; optionally act as the crossbar tail.
  task automatic next();
    @(posedge clk);
    #1;
    if (auto_rsp && m_known) begin
      res_valid = m_hist[0].v;
      res_src   = m_hist[0].s;
    end
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < N; i++) pay[i] = {32'hCAFE_0000 + 32'(i), 32'h0000_1000 + 32'(i)};
    req_payload = {pay[2], pay[1], pay[0]};

    // Reset state
    next(); n_rst = 1'b0; mid();
    chk("lit_rst_xbar_valid", xbar_valid, 0);
    chk("lit_rst_src_err", src_err, 0);
    chk("lit_rst_xbar_src", xbar_src, 0);
    chk("lit_rst_xbar_payload", xbar_payload, 0);

    // All three requesters valid: strict rotation with wrap
    for (int i = 0; i < 6; i++) begin
      next(); n_rst = 1'b1; auto_rsp = 1'b1; req_valid = 3'b111; mid();
      chk("lit_rr_grant", req_ready, 1 << (i % 3));
      if (i >= 1) chk("lit_rr_xbar_src", xbar_src, (i - 1) % 3);
      if (i >= 3) chk("lit_rr_res_steer", res_valid_out, 1 << ((i - 3) % 3));
    end

    // Single requester: full throughput
    for (int i = 0; i < 5; i++) begin
      next(); req_valid = 3'b010; mid();
      chk("lit_single_ready", req_ready, 3'b010);
      if (i >= 1) chk("lit_single_xbar_src", xbar_src, 1);
    end

    // Stall: issue from requester 2, then hold its response off for 3 cycles
    next(); req_valid = 3'b100; mid();
    chk("lit_pre_stall_grant", req_ready, 3'b100);
    for (int i = 0; i < 2; i++) begin
      next(); req_valid = 3'b000; mid();
    end
    for (int i = 0; i < 3; i++) begin
      next(); req_valid = 3'b001; res_ready = 3'b011; mid();
      chk("lit_stall_r_stall", r_stall, 1);
      chk("lit_stall_ready", req_ready, 0);
      chk("lit_stall_steer", res_valid_out, 3'b100);
      chk("lit_stall_xbar_src", xbar_src, 2);
      chk("lit_stall_xbar_payload", xbar_payload, pay[2]);
    end
    next(); res_ready = 3'b111; mid();
    chk("lit_unstall_r_stall", r_stall, 0);
    chk("lit_unstall_grant", req_ready, 3'b001);

    // Write-busy bubbles
    next(); wr_busy = 1'b1; req_valid = 3'b001; mid();
    chk("lit_wb_ready0", req_ready, 0);
    next(); mid();
    chk("lit_wb_ready1", req_ready, 0);
    chk("lit_wb_bubble1", xbar_valid, 0);
    next(); wr_busy = 1'b0; mid();
    chk("lit_wb_grant", req_ready, 3'b001);
    chk("lit_wb_bubble2", xbar_valid, 0);

    // Source error: tail holds src 1, respond with src 0
    for (int i = 0; i < 3; i++) begin
      next(); req_valid = 3'b000; mid();
    end
    next(); req_valid = 3'b010; mid();
    chk("lit_err_issue", req_ready, 3'b010);
    for (int i = 0; i < 2; i++) begin
      next(); req_valid = 3'b000; mid();
    end
    next();
    chk("lit_model_tail", {m_hist[0].v, m_hist[0].s}, 3'b101);
    auto_rsp = 1'b0; res_valid = 1'b1; res_src = 2'd0; mid();
    chk("lit_err_steer", res_valid_out, 3'b001);
    chk("lit_err_before", src_err, 0);
    for (int i = 0; i < 3; i++) begin
      next(); res_valid = 1'b0; mid();
      chk("lit_err_sticky", src_err, 1);
    end

    // Reset with two requests in flight
    auto_rsp = 1'b1;
    for (int i = 0; i < 2; i++) begin
      next(); req_valid = 3'b111; mid();
    end
    next(); n_rst = 1'b0; mid();
    next(); n_rst = 1'b1; auto_rsp = 1'b0; res_valid = 1'b1; res_src = 2'd1; mid();
    chk("lit_mid_rst_xbar_valid", xbar_valid, 0);
    chk("lit_mid_rst_src_err", src_err, 0);
    chk("lit_mid_rst_ptr", req_ready, 3'b001);
    next(); auto_rsp = 1'b1; req_valid = 3'b000; res_valid = 1'b0; mid();
    chk("lit_stale_rsp_err", src_err, 1);
    for (int i = 0; i < 4; i++) begin
      next(); mid();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule
